// File: rtl/network_bank_out.sv
// Output-side bank network: tracks in-flight bank reads and routes the two
// bank read words back to their lanes, flagging reads whose selects collided.
module network_bank_out #(
  parameter int data_width = 12,
  parameter int rd_latency = 2   // legal range 1..4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  sel_a_0,
  input  logic                  sel_a_1,
  input  logic                  flush,
  input  logic [data_width-1:0] q0,
  input  logic [data_width-1:0] q1,
  output logic [data_width-1:0] d0,
  output logic [data_width-1:0] d1,
  output logic                  valid_out,
  output logic                  conflict,
  output logic                  busy
);

  localparam int tail = rd_latency - 1;

  logic [rd_latency-1:0] v_pipe;
  logic [rd_latency-1:0] s0_pipe;
  logic [rd_latency-1:0] s1_pipe;

  logic tail_v;
  logic tail_s0;
  logic tail_s1;

  assign tail_v  = v_pipe[tail];
  assign tail_s0 = s0_pipe[tail];
  assign tail_s1 = s1_pipe[tail];
  assign busy    = |v_pipe;

  // The pipeline never stalls; flush kills every in-flight read, including one issued alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe  <= '0;
      s0_pipe <= '0;
      s1_pipe <= '0;
    end else begin
      v_pipe[0]  <= rd_en & ~flush;
      s0_pipe[0] <= sel_a_0;
      s1_pipe[0] <= sel_a_1;
      for (int k = 1; k < rd_latency; k++) begin
        v_pipe[k]  <= v_pipe[k-1] & ~flush;
        s0_pipe[k] <= s0_pipe[k-1];
        s1_pipe[k] <= s1_pipe[k-1];
      end
    end
  end

  // Inverse of the input routing: the bank that served lane j returns its word to lane j.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0        <= '0;
      d1        <= '0;
      valid_out <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      conflict  <= 1'b0;
      if (tail_v && !flush) begin
        if (tail_s0 != tail_s1) begin
          d0        <= tail_s0 ? q1 : q0;
          d1        <= tail_s0 ? q0 : q1;
          valid_out <= 1'b1;
        end else begin
          conflict  <= 1'b1;
        end
      end
    end
  end

endmodule
